control_sequencer: RTL and testbench
====================================

Name: control_sequencer

Overview:
- Consumer end of the CPU step/T-state interface. It advances its own T-state on each CPU step strobe and decodes the opcode and flags into a registered 16-bit control word.
- Produces the `run` level that feeds the clock generator's halt input: 1 = run, 0 = stop.
- Sits between the clock block and the datapath registers (PC, MAR, RAM, IR, A, B, ALU, OUT) of the 8-bit breadboard-class CPU.

Parameters:
- NUM_STEPS, 5, T-states per instruction; legal 3..8; t_state wraps from NUM_STEPS-1 to 0.
- HALT_OPCODE, 4'hF, opcode whose T2 asserts HLT and latches the halted state.

Ports:
- system_clock  input  1  system clock; all state is posedge.
- clr  input  1  asynchronous, active-high reset.
- step_en  input  1  one-cycle CPU step strobe, synchronous to system_clock; minimum spacing 2 cycles.
- opcode  input  4  instruction register high nibble.
- flag_c  input  1  carry flag.
- flag_z  input  1  zero flag.
- t_state  output  3  current T-state, 0..NUM_STEPS-1.
- t_onehot  output  8  one-hot of t_state, for LEDs.
- ctrl  output  16  registered control word; bits 15..0 = HLT,MI,RI,RO,IO,II,AI,AO,EO,SU,BI,OI,CE,CO,J,FI.
- run  output  1  1 = clock may run; 0 = halted.

Behaviour:
- Reset (clr=1, async): t_state=0, t_onehot=8'h01, ctrl=16'h0000, run=1. After clr falls, ctrl=16'h4004 on the first posedge.
- t_state advances on a posedge with step_en=1 and run=1. It wraps NUM_STEPS-1 -> 0. step_en is ignored while run=0.
- ctrl is re-registered every posedge from decode(t_state, opcode, flags). Latency is 1 cycle after t_state or input change. This is why step_en must be at least 2 cycles apart.
- Decode, any opcode:
  - T0 = 16'h4004 (CO|MI).
  - T1 = 16'h1408 (RO|II|CE).
- Decode at T2/T3/T4 by opcode:
  - 0 NOP: 0 / 0 / 0.
  - 1 LDA: 4800 / 1200 / 0.
  - 2 ADD: 4800 / 1020 / 0281.
  - 3 SUB: 4800 / 1020 / 02C1.
  - 4 STA: 4800 / 2100 / 0.
  - 5 LDI: 0A00 / 0 / 0.
  - 6 JMP: 0802 / 0 / 0.
  - 7 JC: T2 = 0802 if flag_c else 0; rest 0.
  - 8 JZ: T2 = 0802 if flag_z else 0; rest 0.
  - E OUT: 0110 / 0 / 0.
  - HALT_OPCODE: 8000 / 0 / 0.
  - All other opcodes: 0.
- T-states >= 5 (NUM_STEPS > 5) decode to 0.
- Flags are sampled live; the registered ctrl follows them with 1-cycle latency.
- Halt:
  - On the posedge that loads ctrl=16'h8000, run<=0 in the same cycle. The halted state is sticky.
  - While halted: t_state is frozen, ctrl holds 16'h8000, run=0. Only clr exits.
- clr mid-instruction: immediate return to reset values. There is no partial-step memory.
- step_en arriving in the same cycle that run falls is ignored.

Optional Feature:
- Macro EARLY_FETCH_EN.
- When defined: at a step_en with t_state >= 2 and the currently registered ctrl == 0, t_state goes to 0 instead of advancing. This gives short instructions early fetch, e.g. an untaken JC or LDI T3.
- When undefined: every instruction uses all NUM_STEPS steps.
- run and HLT behaviour are identical in both builds.

Test Plan:
- clr pulse, opcode=1; release, 5 step_en spaced 3 cycles -> ctrl sequence 4004,1408,4800,1200,0000; t_state 0,1,2,3,4; t_onehot 01,02,04,08,10; wraps to t_state=0, ctrl=4004.
- opcode=3, step to T4 -> ctrl=02C1. Same with opcode=2 -> ctrl=0281.
- opcode=7, flag_c=1 at T2 -> ctrl=0802. flag_c=0 -> ctrl=0000.
  - With EARLY_FETCH_EN: next step_en -> t_state=0.
  - Without it: t_state=3.
- opcode=F, step to T2 -> ctrl=8000 and run=0 on the same edge. 10 further step_en -> t_state stays 2. clr -> t_state=0, run=1, ctrl=0.
- clr asserted asynchronously between edges while at T3 -> t_state=0, ctrl=0 immediately, without waiting for a clock edge.
- Back-to-back step_en in consecutive cycles (spacing violation) with opcode=5 -> t_state advances on both strobes. ctrl reaches its correct value one cycle after the last strobe.

Source files
------------

// File: rtl/control_sequencer.sv
// T-state sequencer and control-word decoder for the 8-bit breadboard CPU.
// Optional macro EARLY_FETCH_EN: restart fetch as soon as an instruction's remaining steps are idle.
module control_sequencer #(
    parameter int         NUM_STEPS   = 5,
    parameter logic [3:0] HALT_OPCODE = 4'hF
) (
    input  logic        system_clock,
    input  logic        clr,
    input  logic        step_en,
    input  logic [3:0]  opcode,
    input  logic        flag_c,
    input  logic        flag_z,
    output logic [2:0]  t_state,
    output logic [7:0]  t_onehot,
    output logic [15:0] ctrl,
    output logic        run
);

    localparam logic [2:0] LAST_STEP = 3'(NUM_STEPS - 1);

    logic [2:0]  t_state_r;
    logic [7:0]  t_onehot_r;
    logic [15:0] ctrl_r;
    logic        run_r;
    logic [15:0] dec_s;
    logic        step_ok_s;
    logic [2:0]  next_t_s;
    logic [7:0]  next_onehot_s;

    // Control word for a given T-state; bits 15..0 = HLT,MI,RI,RO,IO,II,AI,AO,EO,SU,BI,OI,CE,CO,J,FI
    function automatic logic [15:0] decode(input logic [2:0] t, input logic [3:0] op,
                                           input logic fc, input logic fz);
        logic [15:0] w;
        w = 16'h0000;
        case (t)
            3'd0: w = 16'h4004;
            3'd1: w = 16'h1408;
            3'd2: begin
                if (op == HALT_OPCODE) begin
                    w = 16'h8000;
                end else begin
                    case (op)
                        4'h1:    w = 16'h4800;
                        4'h2:    w = 16'h4800;
                        4'h3:    w = 16'h4800;
                        4'h4:    w = 16'h4800;
                        4'h5:    w = 16'h0A00;
                        4'h6:    w = 16'h0802;
                        4'h7:    w = fc ? 16'h0802 : 16'h0000;
                        4'h8:    w = fz ? 16'h0802 : 16'h0000;
                        4'hE:    w = 16'h0110;
                        default: w = 16'h0000;
                    endcase
                end
            end
            3'd3: begin
                case (op)
                    4'h1:    w = 16'h1200;
                    4'h2:    w = 16'h1020;
                    4'h3:    w = 16'h1020;
                    4'h4:    w = 16'h2100;
                    default: w = 16'h0000;
                endcase
            end
            3'd4: begin
                case (op)
                    4'h2:    w = 16'h0281;
                    4'h3:    w = 16'h02C1;
                    default: w = 16'h0000;
                endcase
            end
            default: w = 16'h0000;
        endcase
        return w;
    endfunction

    // Next-state logic; a strobe coinciding with the halt edge is dropped
    always_comb begin
        dec_s     = decode(t_state_r, opcode, flag_c, flag_z);
        step_ok_s = step_en & run_r & ~dec_s[15];
        if (!step_ok_s) begin
            next_t_s = t_state_r;
        end else if (t_state_r == LAST_STEP) begin
            next_t_s = 3'd0;
`ifdef EARLY_FETCH_EN
        end else if ((t_state_r >= 3'd2) && (ctrl_r == 16'h0000)) begin
            next_t_s = 3'd0;
`endif
        end else begin
            next_t_s = t_state_r + 3'd1;
        end
        next_onehot_s = 8'h01 << next_t_s;
    end

    // Sequencer state; once halted everything freezes until clr
    always_ff @(posedge system_clock or posedge clr) begin
        if (clr) begin
            t_state_r  <= 3'd0;
            t_onehot_r <= 8'h01;
            ctrl_r     <= 16'h0000;
            run_r      <= 1'b1;
        end else if (run_r) begin
            t_state_r  <= next_t_s;
            t_onehot_r <= next_onehot_s;
            ctrl_r     <= dec_s;
            run_r      <= ~dec_s[15];
        end else begin
            t_state_r  <= t_state_r;
            t_onehot_r <= t_onehot_r;
            ctrl_r     <= ctrl_r;
            run_r      <= 1'b0;
        end
    end

    assign t_state  = t_state_r;
    assign t_onehot = t_onehot_r;
    assign ctrl     = ctrl_r;
    assign run      = run_r;

endmodule

// File: tb/tb_control_sequencer.sv
// Directed self-checking bench for control_sequencer.
module tb_control_sequencer;

    logic        system_clock;
    logic        clr;
    logic        step_en;
    logic [3:0]  opcode;
    logic        flag_c;
    logic        flag_z;
    logic [2:0]  t_state;
    logic [7:0]  t_onehot;
    logic [15:0] ctrl;
    logic        run;

    int tests_run = 0;
    int tests_failed = 0;

    control_sequencer dut (
        .system_clock(system_clock),
        .clr(clr),
        .step_en(step_en),
        .opcode(opcode),
        .flag_c(flag_c),
        .flag_z(flag_z),
        .t_state(t_state),
        .t_onehot(t_onehot),
        .ctrl(ctrl),
        .run(run)
    );

    initial system_clock = 1'b0;
    always #5 system_clock = ~system_clock;

    task automatic tick();
        @(posedge system_clock);
        #1;
    endtask

    // one strobe then two idle cycles so ctrl has settled
    task automatic do_step();
        step_en = 1'b1;
        tick();
        step_en = 1'b0;
        tick();
        tick();
    endtask

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic test_reset();
        clr = 1'b1; step_en = 1'b0; opcode = 4'h1; flag_c = 1'b0; flag_z = 1'b0;
        tick();
        tick();
        chk("reset_t_state", {13'd0, t_state}, 16'd0);
        chk("reset_onehot", {8'd0, t_onehot}, 16'h0001);
        chk("reset_ctrl", ctrl, 16'h0000);
        chk("reset_run", {15'd0, run}, 16'd1);
        clr = 1'b0;
        tick();
        chk("first_edge_ctrl", ctrl, 16'h4004);
    endtask

    task automatic test_lda_sequence();
        logic [15:0] exp_ctrl [5];
        exp_ctrl[0] = 16'h4004; exp_ctrl[1] = 16'h1408; exp_ctrl[2] = 16'h4800;
        exp_ctrl[3] = 16'h1200; exp_ctrl[4] = 16'h0000;
        for (int i = 0; i < 5; i++) begin
            if (i > 0) do_step();
            chk($sformatf("lda_t%0d_state", i), {13'd0, t_state}, 16'(i));
            chk($sformatf("lda_t%0d_onehot", i), {8'd0, t_onehot}, 16'(1 << i));
            chk($sformatf("lda_t%0d_ctrl", i), ctrl, exp_ctrl[i]);
        end
        do_step();
        chk("lda_wrap_state", {13'd0, t_state}, 16'd0);
        chk("lda_wrap_ctrl", ctrl, 16'h4004);
    endtask

    task automatic test_alu();
        opcode = 4'h3;
        for (int i = 0; i < 4; i++) do_step();
        chk("sub_t4_ctrl", ctrl, 16'h02C1);
        do_step();
        opcode = 4'h2;
        for (int i = 0; i < 4; i++) do_step();
        chk("add_t4_ctrl", ctrl, 16'h0281);
        do_step();
        chk("add_wrap_state", {13'd0, t_state}, 16'd0);
    endtask

    task automatic test_jc();
        opcode = 4'h7; flag_c = 1'b1;
        do_step();
        do_step();
        chk("jc_taken_ctrl", ctrl, 16'h0802);
        flag_c = 1'b0;
        tick();
        chk("jc_untaken_ctrl", ctrl, 16'h0000);
        do_step();
`ifdef EARLY_FETCH_EN
        chk("jc_next_state", {13'd0, t_state}, 16'd0);
`else
        chk("jc_next_state", {13'd0, t_state}, 16'd3);
        do_step();
        do_step();
`endif
        chk("jc_back_to_t0", {13'd0, t_state}, 16'd0);
    endtask

    task automatic test_halt();
        opcode = 4'hF;
        do_step();
        step_en = 1'b1;
        tick();
        chk("halt_t2_state", {13'd0, t_state}, 16'd2);
        chk("halt_pre_run", {15'd0, run}, 16'd1);
        tick();
        step_en = 1'b0;
        chk("halt_ctrl", ctrl, 16'h8000);
        chk("halt_run", {15'd0, run}, 16'd0);
        chk("halt_same_edge_step_ignored", {13'd0, t_state}, 16'd2);
        opcode = 4'h0;
        for (int i = 0; i < 10; i++) do_step();
        chk("halted_state_frozen", {13'd0, t_state}, 16'd2);
        chk("halted_ctrl_held", ctrl, 16'h8000);
        chk("halted_run", {15'd0, run}, 16'd0);
        #2 clr = 1'b1;
        #1;
        chk("halt_clr_state", {13'd0, t_state}, 16'd0);
        chk("halt_clr_run", {15'd0, run}, 16'd1);
        chk("halt_clr_ctrl", ctrl, 16'h0000);
        clr = 1'b0;
        tick();
    endtask

    task automatic test_async_clr();
        opcode = 4'h1;
        for (int i = 0; i < 3; i++) do_step();
        chk("pre_clr_state", {13'd0, t_state}, 16'd3);
        chk("pre_clr_ctrl", ctrl, 16'h1200);
        #2 clr = 1'b1;
        #1;
        chk("async_clr_state", {13'd0, t_state}, 16'd0);
        chk("async_clr_ctrl", ctrl, 16'h0000);
        chk("async_clr_onehot", {8'd0, t_onehot}, 16'h0001);
        clr = 1'b0;
        tick();
        chk("post_clr_ctrl", ctrl, 16'h4004);
    endtask

    task automatic test_back_to_back();
        opcode = 4'h5;
        step_en = 1'b1;
        tick();
        tick();
        step_en = 1'b0;
        chk("b2b_state", {13'd0, t_state}, 16'd2);
        chk("b2b_onehot", {8'd0, t_onehot}, 16'h0004);
        tick();
        chk("b2b_ctrl", ctrl, 16'h0A00);
    endtask

    initial begin
        test_reset();
        test_lda_sequence();
        test_alu();
        test_jc();
        test_halt();
        test_async_clr();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
